// File: rtl/mem_access_stage.sv
// MEM-stage data-memory access unit.
// Converts load/store controls into a registered req/ack bus transaction,
// stalls the pipeline while the access is outstanding, aligns and extends
// load data into RD, and flags misaligned accesses and bus timeouts.
module mem_access_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  MemSizeM,
    input  logic        MemSignedM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] RD,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_d;
    logic [7:0]  cnt;
    logic [1:0]  size_p1;
    logic [1:0]  off_p1;
    logic        sgn_p1;
    logic        req_any, misaligned, access;
    logic        start, ack_hit, tmo_hit;

    // Half accesses need an even address, word (and size 11) a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return a[0];
            default: return a != 2'b00;
        endcase
    endfunction

    // Byte-enable lanes for the addressed bytes.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data across all lanes so any byte-enable picks it up.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    // Pick the addressed byte/half out of the bus word and sign- or zero-extend it.
    function automatic logic [31:0] load_align(input logic [1:0]  size,
                                               input logic        sgn,
                                               input logic [1:0]  a,
                                               input logic [31:0] rdata);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        b = rdata[{a, 3'b000} +: 8];
        h = a[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            2'b00:   return sgn ? 32'(b) : {24'd0, b};
            2'b01:   return sgn ? 32'(h) : {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    assign req_any    = MemReadM | MemWriteM;
    assign misaligned = is_misaligned(MemSizeM, ALUOutM[1:0]);
    assign access     = req_any & ~misaligned;

    // Stall while launching or waiting; DONE lets the pipeline advance once.
    assign StallM    = ~rst & (((state == IDLE) & access) | (state == BUSY));
    assign MisalignM = (state == IDLE) & req_any & misaligned;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state logic and transaction strobes; an ack beats the timeout.
    always_comb begin
        state_d = state;
        start   = 1'b0;
        ack_hit = 1'b0;
        tmo_hit = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    start   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    ack_hit = 1'b1;
                    state_d = DONE;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    tmo_hit = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Timeout counter: counts BUSY cycles, held at zero elsewhere.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 cnt <= 8'd0;
        else if (state == BUSY)  cnt <= cnt + 8'd1;
        else                     cnt <= 8'd0;
    end

    // Bus request fields are captured at launch and held stable until the response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 30'd0;
            mem_wdata <= 32'd0;
            mem_be    <= 4'd0;
            size_p1   <= 2'd0;
            off_p1    <= 2'd0;
            sgn_p1    <= 1'b0;
        end else if (start) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= ALUOutM[31:2];
            mem_wdata <= lane_wdata(MemSizeM, WriteDataM);
            mem_be    <= lane_be(MemSizeM, ALUOutM[1:0]);
            size_p1   <= MemSizeM;
            off_p1    <= ALUOutM[1:0];
            sgn_p1    <= MemSignedM;
        end else if (ack_hit | tmo_hit) begin
            mem_req   <= 1'b0;
        end
    end

    // Load result and one-cycle timeout pulse; stores leave RD untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RD      <= 32'd0;
            BusErrM <= 1'b0;
        end else begin
            BusErrM <= tmo_hit;
            if (ack_hit & ~mem_we)
                RD <= load_align(size_p1, sgn_p1, off_p1, mem_rdata);
            else if (tmo_hit)
                RD <= 32'd0;
        end
    end

endmodule
